// File: rtl/sqemux_switch_ctrl.sv
// -----------------------------------------------------------------------------
// sqemux_switch_ctrl
//
// Sequencer for the SQEMUX clock-select mux. Every source switch is gated:
// SEN is dropped, the mux is held disabled for DIS_CYCLES, SELECT changes,
// the path settles for SETTLE_CYCLES, then SEN is raised again together
// with a one-cycle ACK.
//
// Ports
//   QCK        in   clock
//   QRT        in   asynchronous active-high reset
//   REQ_VALID  in   switch request valid
//   REQ_SEL    in   requested source (0 = QMUXIN, 1 = SQHSCK)
//   REQ_READY  out  request accepted when REQ_VALID && REQ_READY
//   ACK        out  one-cycle pulse when an accepted request completes
//   BUSY       out  switch sequence in progress
//   SELECT     out  to SQEMUX.SELECT (registered)
//   SEN        out  to SQEMUX.SEN (registered)
//   DEN        out  to SQEMUX.DEN, tied 0 (static mode)
//   DYNEN      out  to SQEMUX.DYNEN, tied 0
//   HS_ALIVE   in   (SQEMUX_CTRL_FALLBACK_EN only) SQHSCK health, sync to QCK
//   FALLBACK   out  (SQEMUX_CTRL_FALLBACK_EN only) set by an autonomous
//                   return to QMUXIN, cleared after the next accepted request
//
// Optional feature macro: SQEMUX_CTRL_FALLBACK_EN
// -----------------------------------------------------------------------------
module sqemux_switch_ctrl #(
  parameter int DIS_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic QCK,
  input  logic QRT,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
`ifdef SQEMUX_CTRL_FALLBACK_EN
  input  logic HS_ALIVE,
  output logic FALLBACK,
`endif
  output logic REQ_READY,
  output logic ACK,
  output logic BUSY,
  output logic SELECT,
  output logic SEN,
  output logic DEN,
  output logic DYNEN
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIS_LOAD    = CNT_W'(DIS_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             select_q, select_d;
  logic             target_q, target_d;
  logic             sen_q, sen_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             auto_q, auto_d;    // current sequence is an autonomous fallback
  logic             trigger;
  logic             accept;
  logic             req_ready;

`ifdef SQEMUX_CTRL_FALLBACK_EN
  logic [1:0] hs_low_q, hs_low_d;      // HS_ALIVE low history, bit0 = last cycle
  logic       fallback_q, fallback_d;

  // Fires once HS_ALIVE has been seen low for two consecutive cycles while
  // idle on SQHSCK. Built only from flops so REQ_READY stays glitch-free.
  assign trigger  = (state_q == ST_IDLE) && select_q && (hs_low_q == 2'b11);
  assign FALLBACK = fallback_q;
`else
  assign trigger = 1'b0;
`endif

  // The trigger takes priority over a user request in the same idle cycle.
  assign req_ready = (state_q == ST_IDLE) && !trigger;
  assign accept    = REQ_VALID && req_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    target_d = target_q;
    sen_d    = sen_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    auto_d   = auto_q;
`ifdef SQEMUX_CTRL_FALLBACK_EN
    hs_low_d   = {hs_low_q[0], ~HS_ALIVE};
    fallback_d = accept ? 1'b0 : fallback_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          target_d = 1'b0;
          auto_d   = 1'b1;
          state_d  = ST_GATE;
          sen_d    = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = DIS_LOAD;
        end else if (accept) begin
          auto_d = 1'b0;
          if (REQ_SEL == select_q) begin
            ack_d = 1'b1;              // already on the requested source
          end else begin
            target_d = REQ_SEL;
            state_d  = ST_GATE;
            sen_d    = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = DIS_LOAD;
          end
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d  = ST_SWAP;
          select_d = target_q;
          cnt_d    = SETTLE_LOAD;
`ifdef SQEMUX_CTRL_FALLBACK_EN
          if (auto_q) fallback_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SWAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          sen_d   = 1'b1;
          busy_d  = 1'b0;
          ack_d   = !auto_q;           // autonomous sequences are not acknowledged
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sen_d   = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      select_q <= 1'b0;
      target_q <= 1'b0;
      sen_q    <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      auto_q   <= 1'b0;
`ifdef SQEMUX_CTRL_FALLBACK_EN
      hs_low_q   <= 2'b00;
      fallback_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      target_q <= target_d;
      sen_q    <= sen_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      auto_q   <= auto_d;
`ifdef SQEMUX_CTRL_FALLBACK_EN
      hs_low_q   <= hs_low_d;
      fallback_q <= fallback_d;
`endif
    end
  end

  assign REQ_READY = req_ready;
  assign ACK       = ack_q;
  assign BUSY      = busy_q;
  assign SELECT    = select_q;
  assign SEN       = sen_q;
  assign DEN       = 1'b0;
  assign DYNEN     = 1'b0;

endmodule

// File: tb/tb_sqemux_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqemux_switch_ctrl
//
// Self-checking bench for sqemux_switch_ctrl with D = S = 4. A directed
// vector table covers reset and the basic switch timing; hand-written
// sequences cover the held request, asynchronous reset mid-switch and
// (when SQEMUX_CTRL_FALLBACK_EN is defined) the autonomous fallback. Random
// requests are checked against a timestamp model: an accepted switch at
// cycle t moves SELECT at t+D+1 and completes at t+D+S+1.
// -----------------------------------------------------------------------------
module tb_sqemux_switch_ctrl;

  localparam int D = 4;
  localparam int S = 4;

  logic QCK = 1'b0;
  logic QRT;
  logic REQ_VALID, REQ_SEL;
  logic REQ_READY, ACK, BUSY, SELECT, SEN, DEN, DYNEN;
`ifdef SQEMUX_CTRL_FALLBACK_EN
  logic HS_ALIVE, FALLBACK;
`endif

  sqemux_switch_ctrl #(.DIS_CYCLES(D), .SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .QCK(QCK),
    .QRT(QRT),
    .REQ_VALID(REQ_VALID),
    .REQ_SEL(REQ_SEL),
`ifdef SQEMUX_CTRL_FALLBACK_EN
    .HS_ALIVE(HS_ALIVE),
    .FALLBACK(FALLBACK),
`endif
    .REQ_READY(REQ_READY),
    .ACK(ACK),
    .BUSY(BUSY),
    .SELECT(SELECT),
    .SEN(SEN),
    .DEN(DEN),
    .DYNEN(DYNEN)
  );

  always #5 QCK = ~QCK;

  int checks = 0;
  int failures = 0;
  int t = 0;

  // Timestamp reference model
  bit m_old, m_tgt;
  int m_sw, m_done, m_ack;

  function automatic bit exp_busy();   return t < m_done;                     endfunction
  function automatic bit exp_select(); return (t >= m_sw) ? m_tgt : m_old;    endfunction
  function automatic bit exp_ack();    return t == m_ack;                     endfunction

  task automatic model_reset();
    t = 0; m_old = 0; m_tgt = 0; m_sw = 0; m_done = 0; m_ack = -1;
  endtask

  task automatic model_apply(input bit valid, input bit sel);
    if (valid && !exp_busy()) begin
      if (sel == exp_select()) begin
        m_ack = t + 1;
      end else begin
        m_old  = exp_select();
        m_tgt  = sel;
        m_sw   = t + D + 1;
        m_done = t + D + S + 1;
        m_ack  = m_done;
      end
    end
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0b exp=%0b", name, t, got, exp);
    end
  endtask

  task automatic step();
    @(posedge QCK);
    #1;
    t++;
  endtask

  // Compare the current cycle against the model, then drive this cycle's request.
  task automatic do_cycle(input bit valid, input bit sel);
    chk("select", SELECT, exp_select());
    chk("sen", SEN, !exp_busy());
    chk("busy", BUSY, exp_busy());
    chk("ready", REQ_READY, !exp_busy());
    chk("ack", ACK, exp_ack());
    chk("den", DEN, 1'b0);
    chk("dynen", DYNEN, 1'b0);
    REQ_VALID = valid;
    REQ_SEL   = sel;
    model_apply(valid, sel);
    step();
  endtask

  typedef struct {
    bit valid;
    bit sel;
    bit e_select;
    bit e_sen;
    bit e_busy;
    bit e_ack;
    bit e_ready;
  } vec_t;

  function automatic vec_t mk(bit v, bit s, bit es, bit en, bit eb, bit ea, bit er);
    vec_t r;
    r.valid = v; r.sel = s; r.e_select = es; r.e_sen = en;
    r.e_busy = eb; r.e_ack = ea; r.e_ready = er;
    return r;
  endfunction

  vec_t vecs[13];

  initial begin
    // Rows: inputs applied this cycle, outputs expected this cycle.
    vecs[0]  = mk(1, 0, 0, 1, 0, 0, 1);   // reset state; same-source request
    vecs[1]  = mk(0, 0, 0, 1, 0, 1, 1);   // ACK one cycle later, no pin change
    vecs[2]  = mk(1, 1, 0, 1, 0, 0, 1);   // switch to 1 accepted (cycle 0)
    for (int i = 3; i <= 6; i++)  vecs[i] = mk(0, 0, 0, 0, 1, 0, 0); // gate
    for (int i = 7; i <= 10; i++) vecs[i] = mk(0, 0, 1, 0, 1, 0, 0); // settle
    vecs[11] = mk(0, 0, 1, 1, 0, 1, 1);   // cycle 9: SEN, ACK, READY
    vecs[12] = mk(0, 0, 1, 1, 0, 0, 1);

    QRT = 1'b1; REQ_VALID = 1'b0; REQ_SEL = 1'b0;
`ifdef SQEMUX_CTRL_FALLBACK_EN
    HS_ALIVE = 1'b1;
`endif
    repeat (3) @(posedge QCK);
    #1;
    QRT = 1'b0;
    model_reset();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_select", i), SELECT, vecs[i].e_select);
      chk($sformatf("tbl%0d_sen", i), SEN, vecs[i].e_sen);
      chk($sformatf("tbl%0d_busy", i), BUSY, vecs[i].e_busy);
      chk($sformatf("tbl%0d_ack", i), ACK, vecs[i].e_ack);
      chk($sformatf("tbl%0d_ready", i), REQ_READY, vecs[i].e_ready);
      chk($sformatf("tbl%0d_den", i), DEN, 1'b0);
      chk($sformatf("tbl%0d_dynen", i), DYNEN, 1'b0);
      REQ_VALID = vecs[i].valid;
      REQ_SEL   = vecs[i].sel;
      model_apply(vecs[i].valid, vecs[i].sel);
      step();
    end

    // Return to source 0, then a held request during a switch to 1.
    do_cycle(1, 0);
    repeat (9) do_cycle(0, 0);
    for (int k = 0; k < 20; k++) begin
      if (k == 9 || k == 18) chk($sformatf("held_ack_k%0d", k), ACK, 1'b1);
      if (k == 18) chk("held_select", SELECT, 1'b0);
      do_cycle(k == 0 || (k >= 3 && k <= 9), k == 0);
    end

    // Asynchronous reset at cycle 6 of a switch to 1.
    do_cycle(1, 1);
    repeat (5) do_cycle(0, 0);
    chk("pre_rst_select", SELECT, 1'b1);
    chk("pre_rst_sen", SEN, 1'b0);
    #3;
    QRT = 1'b1;
    #1;
    chk("rst_select", SELECT, 1'b0);
    chk("rst_sen", SEN, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_ready", REQ_READY, 1'b1);
    @(posedge QCK);
    #1;
    chk("rst_hold_ack", ACK, 1'b0);
    QRT = 1'b0;
    model_reset();

    // Random requests against the model
    repeat (400) do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

`ifdef SQEMUX_CTRL_FALLBACK_EN
    begin
      bit done;
      for (int i = 0; i < 20 && exp_busy(); i++) do_cycle(0, 0);
      if (!exp_select()) begin
        do_cycle(1, 1);
        repeat (9) do_cycle(0, 0);
      end
      chk("fb_start_select", SELECT, 1'b1);
      chk("fb_start_flag", FALLBACK, 1'b0);
      REQ_VALID = 1'b0;
      HS_ALIVE  = 1'b0;
      done = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        chk("fb_no_ack", ACK, 1'b0);
        if (SELECT == 1'b0 && BUSY == 1'b0) begin
          done = 1;
          break;
        end
      end
      chk("fb_completed", done, 1'b1);
      chk("fb_flag_set", FALLBACK, 1'b1);
      chk("fb_sen", SEN, 1'b1);
      HS_ALIVE = 1'b1;
      step();
      chk("fb_flag_kept", FALLBACK, 1'b1);
      chk("fb_ready", REQ_READY, 1'b1);
      REQ_VALID = 1'b1;
      REQ_SEL   = 1'b0;
      step();
      REQ_VALID = 1'b0;
      chk("fb_flag_clear", FALLBACK, 1'b0);
      chk("fb_req_ack", ACK, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
